// File: rtl/prf_pend_tracker.sv
// ---------------------------------------------------------------------------
// prf_pend_tracker
//   Pending-bit scoreboard for the integer physical register file. Each
//   physical register has one bit that is set when rename allocates it as a
//   destination and cleared when a PRF writeback targets it. Rename queries
//   the table for every source of every lane in a bundle. Each query gets a
//   0-cycle answer that accounts for allocations by older lanes in the same
//   bundle and for writebacks happening in the same cycle.
//
// Ports
//   clk         clock
//   reset       synchronous active-high reset; forces o_pend low while high
//   wr_en       per writeback port valid
//   wr_pdst     per writeback port destination preg
//   alloc_en    per rename lane allocate-valid (lane 0 is oldest)
//   alloc_pdst  per rename lane newly allocated preg
//   lkup_psrc   per lane, per source operand preg to query
//   o_pend      per lane, per source: 1 = value not yet written
//   flush       clears every pending bit; alloc/wr ignored that cycle
//   o_num_pend  registered number of pending pregs
// ---------------------------------------------------------------------------
module prf_pend_tracker #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_WR    = 3,
    parameter int NUM_LANES = 2,
    parameter int NUM_SRCS  = 2,
    parameter int PREG_W    = $clog2(NUM_PREGS),
    parameter int CNT_W     = $clog2(NUM_PREGS + 1)
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [NUM_WR-1:0]                                wr_en,
    input  logic [NUM_WR-1:0][PREG_W-1:0]                    wr_pdst,
    input  logic [NUM_LANES-1:0]                             alloc_en,
    input  logic [NUM_LANES-1:0][PREG_W-1:0]                 alloc_pdst,
    input  logic [NUM_LANES-1:0][NUM_SRCS-1:0][PREG_W-1:0]   lkup_psrc,
    output logic [NUM_LANES-1:0][NUM_SRCS-1:0]               o_pend,
    input  logic                                             flush,
    output logic [CNT_W-1:0]                                 o_num_pend
);

    // Pending table and its registered population count.
    logic [NUM_PREGS-1:0]                 pend_r;
    logic [CNT_W-1:0]                     num_pend_r;

    logic [NUM_PREGS-1:0]                 set_vec_s;
    logic [NUM_PREGS-1:0]                 clr_vec_s;
    logic [NUM_PREGS-1:0]                 pend_next_s;
    logic [CNT_W-1:0]                     num_pend_next_s;
    logic [NUM_LANES-1:0][NUM_SRCS-1:0]   pend_s;

    // True when a lane older than 'lane' allocates preg p in this bundle.
    function automatic logic older_alloc_hit(
        input int                               lane,
        input logic [PREG_W-1:0]                p,
        input logic [NUM_LANES-1:0]             en,
        input logic [NUM_LANES-1:0][PREG_W-1:0] pdst
    );
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            hit = hit | ((k < lane) && en[k] && (pdst[k] == p));
        end
        return hit;
    endfunction

    // True when any writeback port writes preg p this cycle.
    function automatic logic wr_hit(
        input logic [PREG_W-1:0]             p,
        input logic [NUM_WR-1:0]             en,
        input logic [NUM_WR-1:0][PREG_W-1:0] pdst
    );
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < NUM_WR; w++) begin
            hit = hit | (en[w] && (pdst[w] == p));
        end
        return hit;
    endfunction

    // Number of set bits in a pending vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_PREGS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_PREGS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Source lookup: zero reg, then older-lane alloc, then writeback bypass, then table.
    // A lane's own alloc is deliberately excluded: its sources read the old mapping.
    always_comb begin
        pend_s = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int s = 0; s < NUM_SRCS; s++) begin
                if (reset) begin
                    pend_s[l][s] = 1'b0;
                end else if (lkup_psrc[l][s] == '0) begin
                    pend_s[l][s] = 1'b0;
                end else if (older_alloc_hit(l, lkup_psrc[l][s], alloc_en, alloc_pdst)) begin
                    pend_s[l][s] = 1'b1;
                end else if (wr_hit(lkup_psrc[l][s], wr_en, wr_pdst)) begin
                    pend_s[l][s] = 1'b0;
                end else begin
                    pend_s[l][s] = pend_r[lkup_psrc[l][s]];
                end
            end
        end
    end

    // Decode allocations (preg 0 excluded) and writebacks into per-preg set/clear vectors.
    always_comb begin
        set_vec_s = '0;
        clr_vec_s = '0;
        for (int p = 0; p < NUM_PREGS; p++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                set_vec_s[p] = set_vec_s[p] |
                               (alloc_en[l] && (alloc_pdst[l] == PREG_W'(p)) &&
                                (alloc_pdst[l] != '0));
            end
            for (int w = 0; w < NUM_WR; w++) begin
                clr_vec_s[p] = clr_vec_s[p] | (wr_en[w] && (wr_pdst[w] == PREG_W'(p)));
            end
        end
    end

    // Next table: flush wipes everything; otherwise set wins over clear so a
    // preg written and reallocated in the same cycle stays pending.
    always_comb begin
        pend_next_s = pend_r;
        if (flush) begin
            pend_next_s = '0;
        end else begin
            pend_next_s = set_vec_s | (pend_r & ~clr_vec_s);
        end
        num_pend_next_s = popcount(pend_next_s);
    end

    // State register; reset overrides flush, alloc and writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r     <= '0;
            num_pend_r <= '0;
        end else begin
            pend_r     <= pend_next_s;
            num_pend_r <= num_pend_next_s;
        end
    end

    // Output drive.
    always_comb begin
        o_pend     = pend_s;
        o_num_pend = num_pend_r;
    end

    prf_pend_tracker_chk #(
        .NUM_PREGS (NUM_PREGS),
        .NUM_WR    (NUM_WR),
        .NUM_LANES (NUM_LANES),
        .PREG_W    (PREG_W)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_pdst    (wr_pdst),
        .alloc_en   (alloc_en),
        .alloc_pdst (alloc_pdst),
        .pend_r     (pend_r)
    );

endmodule

// ---------------------------------------------------------------------------
// prf_pend_tracker_chk
//   Protocol checks on the tracker's inputs, evaluated at each clock edge
//   outside reset: no X on the enables, no duplicate alloc_pdst within a
//   bundle, and no allocation of a preg that is still pending unless a
//   writeback clears it in the same cycle.
//
// Ports
//   clk, reset              clock and synchronous reset of the tracker
//   wr_en, wr_pdst          writeback ports
//   alloc_en, alloc_pdst    rename allocations
//   pend_r                  current pending table
// ---------------------------------------------------------------------------
module prf_pend_tracker_chk #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_WR    = 3,
    parameter int NUM_LANES = 2,
    parameter int PREG_W    = $clog2(NUM_PREGS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_WR-1:0]                wr_en,
    input  logic [NUM_WR-1:0][PREG_W-1:0]    wr_pdst,
    input  logic [NUM_LANES-1:0]             alloc_en,
    input  logic [NUM_LANES-1:0][PREG_W-1:0] alloc_pdst,
    input  logic [NUM_PREGS-1:0]             pend_r
);

    logic dup_s;
    logic stale_s;

    // Two enabled lanes naming the same preg.
    function automatic logic dup_alloc(
        input logic [NUM_LANES-1:0]             en,
        input logic [NUM_LANES-1:0][PREG_W-1:0] pdst
    );
        logic d;
        d = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = 0; j < NUM_LANES; j++) begin
                d = d | ((i < j) && en[i] && en[j] && (pdst[i] == pdst[j]));
            end
        end
        return d;
    endfunction

    // An enabled lane allocating a still-pending preg that no writeback clears now.
    function automatic logic stale_alloc(
        input logic [NUM_LANES-1:0]             en,
        input logic [NUM_LANES-1:0][PREG_W-1:0] pdst,
        input logic [NUM_WR-1:0]                wen,
        input logic [NUM_WR-1:0][PREG_W-1:0]    wpdst,
        input logic [NUM_PREGS-1:0]             pend
    );
        logic bad;
        logic cleared;
        bad = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            cleared = 1'b0;
            for (int w = 0; w < NUM_WR; w++) begin
                cleared = cleared | (wen[w] && (wpdst[w] == pdst[l]));
            end
            bad = bad | (en[l] && (pdst[l] != '0) && pend[pdst[l]] && !cleared);
        end
        return bad;
    endfunction

    // Evaluate the bundle-level violation flags.
    always_comb begin
        dup_s   = dup_alloc(alloc_en, alloc_pdst);
        stale_s = stale_alloc(alloc_en, alloc_pdst, wr_en, wr_pdst, pend_r);
    end

    // Sample the checks on each active edge outside reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!$isunknown(wr_en))
                else $error("prf_pend_tracker: X on wr_en");
            assert (!$isunknown(alloc_en))
                else $error("prf_pend_tracker: X on alloc_en");
            assert (!dup_s)
                else $error("prf_pend_tracker: duplicate alloc_pdst in bundle");
            assert (!stale_s)
                else $error("prf_pend_tracker: alloc_pdst already pending");
        end
    end

endmodule
